// File: rtl/flash_addr_pkg.sv
// Shared types and default window for the flash word-address controller.
package flash_addr_pkg;

  typedef enum logic [1:0] {
    PAUSED,
    PLAYING,
    ENDED
  } addr_state_t;

  localparam int unsigned  DEF_ADDR_W     = 23;
  localparam logic [22:0]  DEF_START_ADDR = 23'h000000;
  localparam logic [22:0]  DEF_END_ADDR   = 23'h07FFFF;

endpackage

// File: rtl/flash_address_controller.sv
// Word-address generator for the flash read sequencer: pause/play, fwd/reverse, window boundaries.
// Define FLASH_ADDR_LOOP_EN to wrap at the window edges instead of stopping in ENDED.
module flash_address_controller
  import flash_addr_pkg::*;
#(
  parameter int unsigned        ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0]  START_ADDR = ADDR_W'(DEF_START_ADDR),
  parameter logic [ADDR_W-1:0]  END_ADDR   = ADDR_W'(DEF_END_ADDR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  input  logic              addr_reset,
  input  logic              play,
  input  logic              reverse,
  output logic [ADDR_W-1:0] address,
  output logic              wrapped,
  output logic              at_end
);

  addr_state_t       r_state;
  addr_state_t       w_stateNext;
  logic [ADDR_W-1:0] r_address;
  logic [ADDR_W-1:0] w_addressNext;
  logic              r_wrapped;
  logic              w_wrappedNext;
  logic              w_fwd;
  logic              w_back;

  always_comb begin
    w_fwd         = 1'b0;
    w_back        = 1'b0;
    w_stateNext   = r_state;
    w_addressNext = r_address;
    w_wrappedNext = 1'b0;

    // inc and dec swap meaning when reverse is set; both together cancel out
    if (inc ^ dec) begin
      w_fwd  = inc ^ reverse;
      w_back = ~(inc ^ reverse);
    end

    if (addr_reset) begin
      w_addressNext = reverse ? END_ADDR : START_ADDR;
      if (r_state == ENDED) begin
        w_stateNext = play ? PLAYING : PAUSED;
      end
    end else begin
      if (r_state == PLAYING) begin
        if (w_fwd) begin
          if (r_address == END_ADDR) begin
            w_wrappedNext = 1'b1;
`ifdef FLASH_ADDR_LOOP_EN
            w_addressNext = START_ADDR;
`else
            w_stateNext   = ENDED;
`endif
          end else begin
            w_addressNext = r_address + 1'b1;
          end
        end else if (w_back) begin
          if (r_address == START_ADDR) begin
            w_wrappedNext = 1'b1;
`ifdef FLASH_ADDR_LOOP_EN
            w_addressNext = END_ADDR;
`else
            w_stateNext   = ENDED;
`endif
          end else begin
            w_addressNext = r_address - 1'b1;
          end
        end
      end

      // A boundary stop outranks the play/pause level in the same cycle
      if (w_stateNext != ENDED) begin
        if (r_state == PAUSED && play) begin
          w_stateNext = PLAYING;
        end else if (r_state == PLAYING && !play) begin
          w_stateNext = PAUSED;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= PAUSED;
      r_address <= START_ADDR;
      r_wrapped <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_address <= w_addressNext;
      r_wrapped <= w_wrappedNext;
    end
  end

  assign address = r_address;
  assign wrapped = r_wrapped;

`ifdef FLASH_ADDR_LOOP_EN
  assign at_end = 1'b0;
`else
  logic r_atEnd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_atEnd <= 1'b0;
    end else begin
      r_atEnd <= (w_stateNext == ENDED);
    end
  end

  assign at_end = r_atEnd;
`endif

endmodule

// File: tb/tb_flash_address_controller.sv
// Scoreboard bench for flash_address_controller: a 4-word window DUT and a single-word window DUT
// driven in lockstep; expectations come from a behavioural model pushed into per-DUT queues.
module tb_flash_address_controller;

  localparam logic [22:0] WIN_START = 23'h10;
  localparam logic [22:0] WIN_END   = 23'h13;
  localparam logic [22:0] ONE_ADDR  = 23'h20;

`ifdef FLASH_ADDR_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam int M_PAUSED  = 0;
  localparam int M_PLAYING = 1;
  localparam int M_ENDED   = 2;

  typedef struct packed {
    logic [22:0] addr;
    logic        wrap;
    logic        atEnd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inc = 1'b0;
  logic        dec = 1'b0;
  logic        addrReset = 1'b0;
  logic        play = 1'b0;
  logic        reverse = 1'b0;
  logic [22:0] address0;
  logic        wrapped0;
  logic        atEnd0;
  logic [22:0] address1;
  logic        wrapped1;
  logic        atEnd1;

  exp_t        q0[$];
  exp_t        q1[$];
  int          mState[2];
  logic [22:0] mAddr[2];
  logic [22:0] winLo[2];
  logic [22:0] winHi[2];
  logic        curPlay = 1'b0;
  logic        curRev = 1'b0;
  int          assertCount = 0;
  int          failCount = 0;

  always #5 clk = ~clk;

  flash_address_controller #(
    .ADDR_W(23), .START_ADDR(WIN_START), .END_ADDR(WIN_END)
  ) dutWindow (
    .clk(clk), .reset(reset), .inc(inc), .dec(dec), .addr_reset(addrReset),
    .play(play), .reverse(reverse), .address(address0), .wrapped(wrapped0), .at_end(atEnd0)
  );

  flash_address_controller #(
    .ADDR_W(23), .START_ADDR(ONE_ADDR), .END_ADDR(ONE_ADDR)
  ) dutSingle (
    .clk(clk), .reset(reset), .inc(inc), .dec(dec), .addr_reset(addrReset),
    .play(play), .reverse(reverse), .address(address1), .wrapped(wrapped1), .at_end(atEnd1)
  );

  // Reference behaviour for one DUT, written from the playback rules rather than the RTL structure
  task automatic modelStep(input int k, input logic iRst, input logic iInc, input logic iDec,
                           input logic iAr, input logic iPlay, input logic iRev);
    logic wrap;
    logic goFwd;
    logic goBack;
    int   nextState;
    exp_t e;
    wrap      = 1'b0;
    nextState = mState[k];
    goFwd     = (iInc && !iDec && !iRev) || (iDec && !iInc && iRev);
    goBack    = (iInc && !iDec && iRev) || (iDec && !iInc && !iRev);
    if (iRst) begin
      mAddr[k]  = winLo[k];
      nextState = M_PAUSED;
    end else if (iAr) begin
      mAddr[k] = iRev ? winHi[k] : winLo[k];
      if (mState[k] == M_ENDED) nextState = iPlay ? M_PLAYING : M_PAUSED;
    end else begin
      if (mState[k] == M_PLAYING && goFwd) begin
        if (mAddr[k] == winHi[k]) begin
          wrap = 1'b1;
          if (LOOP) mAddr[k] = winLo[k];
          else nextState = M_ENDED;
        end else begin
          mAddr[k] = mAddr[k] + 23'd1;
        end
      end else if (mState[k] == M_PLAYING && goBack) begin
        if (mAddr[k] == winLo[k]) begin
          wrap = 1'b1;
          if (LOOP) mAddr[k] = winHi[k];
          else nextState = M_ENDED;
        end else begin
          mAddr[k] = mAddr[k] - 23'd1;
        end
      end
      if (nextState != M_ENDED) begin
        if (mState[k] == M_PAUSED && iPlay) nextState = M_PLAYING;
        else if (mState[k] == M_PLAYING && !iPlay) nextState = M_PAUSED;
      end
    end
    mState[k] = nextState;
    e.addr  = mAddr[k];
    e.wrap  = wrap;
    e.atEnd = (mState[k] == M_ENDED);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Called at a falling edge: drive inputs and record what both DUTs must show after the next rise
  task automatic applyStimulus(input logic iRst, input logic iInc, input logic iDec, input logic iAr);
    reset     = iRst;
    inc       = iInc;
    dec       = iDec;
    addrReset = iAr;
    play      = curPlay;
    reverse   = curRev;
    modelStep(0, iRst, iInc, iDec, iAr, curPlay, curRev);
    modelStep(1, iRst, iInc, iDec, iAr, curPlay, curRev);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e0;
    exp_t e1;
    if (q0.size() == 0 || q1.size() == 0) begin
      assertCount++;
      failCount++;
      $error("[TB] FAIL %s scoreboard empty observed=%0d expected=nonzero", tag, q0.size());
      return;
    end
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    assertCount++;
    assert (address0 === e0.addr) else begin
      failCount++;
      $error("[TB] FAIL %s address observed=%h expected=%h", tag, address0, e0.addr);
    end
    assertCount++;
    assert (wrapped0 === e0.wrap) else begin
      failCount++;
      $error("[TB] FAIL %s wrapped observed=%b expected=%b", tag, wrapped0, e0.wrap);
    end
    assertCount++;
    assert (atEnd0 === e0.atEnd) else begin
      failCount++;
      $error("[TB] FAIL %s at_end observed=%b expected=%b", tag, atEnd0, e0.atEnd);
    end
    assertCount++;
    assert (address1 === e1.addr) else begin
      failCount++;
      $error("[TB] FAIL %s single_address observed=%h expected=%h", tag, address1, e1.addr);
    end
    assertCount++;
    assert (wrapped1 === e1.wrap) else begin
      failCount++;
      $error("[TB] FAIL %s single_wrapped observed=%b expected=%b", tag, wrapped1, e1.wrap);
    end
    assertCount++;
    assert (atEnd1 === e1.atEnd) else begin
      failCount++;
      $error("[TB] FAIL %s single_at_end observed=%b expected=%b", tag, atEnd1, e1.atEnd);
    end
  endtask

  task automatic cycle(input string tag, input logic iRst, input logic iInc,
                       input logic iDec, input logic iAr);
    applyStimulus(iRst, iInc, iDec, iAr);
    @(posedge clk);
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    winLo[0]  = WIN_START;
    winHi[0]  = WIN_END;
    winLo[1]  = ONE_ADDR;
    winHi[1]  = ONE_ADDR;
    mState[0] = M_PAUSED;
    mState[1] = M_PAUSED;
    mAddr[0]  = WIN_START;
    mAddr[1]  = ONE_ADDR;
    @(negedge clk);

    cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("reset_hold", 1'b1, 1'b0, 1'b0, 1'b0);

    curPlay = 1'b1;
    cycle("play_start", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle("inc_fwd", 1'b0, 1'b1, 1'b0, 1'b0);
      cycle("inc_gap", 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("inc_gap", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cycle("restart_fwd", 1'b0, 1'b0, 1'b0, 1'b1);

    curRev = 1'b1;
    cycle("rev_inc_boundary", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("rev_gap", 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("rev_dec_boundary", 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("rev_gap", 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("restart_rev", 1'b0, 1'b0, 1'b0, 1'b1);
    curRev = 1'b0;
    cycle("restart_fwd2", 1'b0, 1'b0, 1'b0, 1'b1);

    curPlay = 1'b0;
    cycle("pause_enter", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle("paused_inc", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    curPlay = 1'b1;
    cycle("resume", 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("resume_inc", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("inc_to_12", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("inc_and_dec", 1'b0, 1'b1, 1'b1, 1'b0);
    cycle("ar_with_inc", 1'b0, 1'b1, 1'b0, 1'b1);

    cycle("back_boundary", 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("back_again", 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("restart_after_back", 1'b0, 1'b0, 1'b0, 1'b1);

    cycle("inc_a", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("inc_b", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("reset_with_inc", 1'b1, 1'b1, 1'b0, 1'b0);
    cycle("post_reset_inc", 1'b0, 1'b1, 1'b0, 1'b0);
    cycle("playing_inc", 1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      curPlay = ($urandom_range(3) != 0);
      curRev  = $urandom_range(1);
      cycle("random", ($urandom_range(29) == 0), $urandom_range(1), $urandom_range(1),
            ($urandom_range(7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/flash_address_controller.md
Name: flash_address_controller

Overview:
- Maintains the 32-bit-word flash address consumed by the flash read sequencer.
- Sits directly downstream of the reader's inc/dec/reset control outputs and upstream of the flash address bus.
- Provides pause and play, forward or reverse playback, and boundary handling within a configurable sample window [START_ADDR, END_ADDR].

Parameters:
- ADDR_W, 23, width of the word address driven to flash.
- START_ADDR, 23'h000000, first word of the audio window (inclusive).
- END_ADDR, 23'h07FFFF, last word of the audio window (inclusive); must be >= START_ADDR.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- inc  in  1  one-cycle step request from the flash reader.
- dec  in  1  one-cycle reverse-step request from the flash reader.
- addr_reset  in  1  one-cycle restart request from the flash reader (the reader's "reset" output).
- play  in  1  level; 1 = run, 0 = pause.
- reverse  in  1  level; 1 = playback direction backward.
- address  out  ADDR_W  current word address to flash.
- wrapped  out  1  one-cycle pulse when the address crosses a window boundary.
- at_end  out  1  level; high while in ENDED state (0 when FLASH_ADDR_LOOP_EN is defined).

Behaviour:
- Reset is synchronous, active-high, and sampled only on posedge clk:
  - address = START_ADDR.
  - state = PAUSED.
  - wrapped = 0.
  - at_end = 0.
- All outputs are registered. The address changes on the first clk edge after a qualifying request; latency is 1 cycle.
- Step decode (combinational, evaluated each cycle):
  - inc & dec together = no step (hold).
  - inc alone = fwd when reverse = 0, back when reverse = 1.
  - dec alone = back when reverse = 0, fwd when reverse = 1.
- States: PAUSED, PLAYING, ENDED.
- PAUSED:
  - Goes to PLAYING when play = 1.
  - Steps are ignored.
  - addr_reset is honoured.
- PLAYING:
  - Goes to PAUSED when play = 0. A step in that same cycle is still applied, because the step is decided from the current state.
  - fwd: address + 1. If address == END_ADDR, go to START_ADDR and pulse wrapped.
  - back: address - 1. If address == START_ADDR, go to END_ADDR and pulse wrapped.
- ENDED (only reachable without FLASH_ADDR_LOOP_EN):
  - Address holds.
  - Steps are ignored.
  - Left only via addr_reset or reset.
- addr_reset:
  - Load START_ADDR if reverse = 0, END_ADDR if reverse = 1.
  - Takes priority over any step in the same cycle.
  - wrapped = 0 that cycle.
  - From ENDED, go to PLAYING if play = 1, else PAUSED. Other states keep their state.
- Overall priority: reset > addr_reset > step > play transition.
- Arithmetic is unsigned, ADDR_W bits. The address never leaves [START_ADDR, END_ADDR].
- START_ADDR == END_ADDR: every step is a boundary step. Address is constant and wrapped pulses on each step.
- wrapped is high for exactly one cycle per boundary event. It is never held high across consecutive cycles unless consecutive boundary steps occur.
- A reverse change takes effect on the next step. The address is not altered when reverse toggles.

Optional Feature:
- Macro: FLASH_ADDR_LOOP_EN.
- Defined: boundary steps wrap as described above. ENDED is never entered and at_end is tied to 0.
- Undefined:
  - A boundary step does not move the address; it stays at END_ADDR (fwd) or START_ADDR (back).
  - wrapped pulses once and the state goes to ENDED.
  - at_end = 1 until addr_reset or reset.

Decomposition:
- Package flash_addr_pkg contains:
  - typedef enum logic [1:0] addr_state_t {PAUSED, PLAYING, ENDED}.
  - localparam defaults for ADDR_W, START_ADDR and END_ADDR.
- No sub-module. The step decode and the boundary/next-address logic live in one always_comb block, with a single always_ff for state, address and wrapped.

Test Plan (bench parameters START_ADDR = 0x10, END_ADDR = 0x13, loop enabled unless noted):
- Reset, then play = 1 and 5 inc pulses spaced 3 cycles -> address 0x11, 0x12, 0x13, 0x10, 0x11; wrapped pulses exactly once, on the 0x13->0x10 edge.
- reverse = 1 at address 0x10, 1 inc pulse -> address 0x13 next cycle, wrapped = 1 for one cycle. Then 1 dec pulse with reverse = 1 -> 0x10 with wrapped.
- play = 0, 3 inc pulses -> address unchanged, state PAUSED. Then play = 1, 1 inc -> address + 1.
- inc and dec asserted together at 0x12 -> address stays 0x12. Then addr_reset with inc in the same cycle, reverse = 0 -> address 0x10.
- Macro undefined, address 0x13, inc -> address stays 0x13, wrapped one pulse, at_end = 1. Further incs have no effect. addr_reset with play = 1 -> address 0x10, at_end = 0, state PLAYING.
- Reset asserted mid-run at 0x12 with inc in the same cycle -> address 0x10, state PAUSED, wrapped = 0 on the next edge.
